bitmanip_multicycle: RTL and testbench

BITMANIP_MULTICYCLE -- requirements
Module: bitmanip_multicycle

---
 rtl/ariane_pkg.sv | 13 +
 rtl/bitmanip_step.sv | 60 ++++++
 rtl/bitmanip_multicycle.sv | 191 +++++++++++++++++++
 tb/tb_bitmanip_multicycle.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ariane_pkg.sv
// ariane_pkg -- shared types for the bit-manipulation unit.
//
// Contents:
//   bitmanip_op_e : operation select for the multi-cycle unit
//                   (BEXT = bit extract, BDEP = bit deposit).
package ariane_pkg;

    typedef enum logic {
        BEXT = 1'b0,
        BDEP = 1'b1
    } bitmanip_op_e;

endpackage

// File: rtl/bitmanip_step.sv
// bitmanip_step -- combinational kernel that handles one mask slice.
//
// Walks BITS_PER_CYCLE mask bits LSB first. For every set bit it either
// gathers a data bit into the packed position k (BEXT) or scatters data
// bit k into the mask position (BDEP). It then advances k.
//
// Ports:
//   op_i    : BEXT or BDEP
//   a_i     : full data operand (XLEN)
//   slice_i : current BITS_PER_CYCLE-wide mask slice
//   base_i  : bit position of slice_i[0] within the full mask
//   k_i     : number of set mask bits seen so far
//   acc_i   : accumulator before this slice
//   acc_o   : accumulator after this slice
//   k_o     : updated set-bit count
module bitmanip_step
    import ariane_pkg::*;
#(
    parameter int unsigned XLEN           = 64,
    parameter int unsigned BITS_PER_CYCLE = 8,
    localparam int unsigned IW            = $clog2(XLEN),
    localparam int unsigned KW            = IW + 1
) (
    input  bitmanip_op_e              op_i,
    input  logic [XLEN-1:0]           a_i,
    input  logic [BITS_PER_CYCLE-1:0] slice_i,
    input  logic [IW-1:0]             base_i,
    input  logic [KW-1:0]             k_i,
    input  logic [XLEN-1:0]           acc_i,
    output logic [XLEN-1:0]           acc_o,
    output logic [KW-1:0]             k_o
);

    logic [XLEN-1:0] acc;
    logic [KW-1:0]   k;
    logic [IW-1:0]   pos;

    // k stays below XLEN whenever a mask bit is set, because k counts
    // only the set bits that come before the current one. The truncated
    // index is therefore always in range when it is used.
    always_comb begin
        acc = acc_i;
        k   = k_i;
        pos = '0;
        for (int j = 0; j < int'(BITS_PER_CYCLE); j++) begin
            pos = base_i + IW'(j);
            if (slice_i[j]) begin
                if (op_i == BEXT) begin
                    acc[k[IW-1:0]] = a_i[pos];
                end else begin
                    acc[pos] = a_i[k[IW-1:0]];
                end
                k = k + KW'(1);
            end
        end
        acc_o = acc;
        k_o   = k;
    end

endmodule

// File: rtl/bitmanip_multicycle.sv
// bitmanip_multicycle -- iterative BEXT/BDEP unit, BITS_PER_CYCLE mask bits
// per clock.
//
// Flow: IDLE (ready_o) -> BUSY (one mask slice per cycle) -> DONE (valid_o,
// the result is held until ready_i). A flush returns the unit to IDLE from
// any state and discards the result.
//
// Ports:
//   clk_i, rst_ni          : clock and asynchronous active-low reset
//   flush_i                : abort the in-flight op (beats valid_i/ready_i)
//   valid_i / ready_o      : request handshake
//   op_i, word_i           : operation, and the 32-bit W variant
//   operand_a_i            : data
//   operand_b_i            : mask
//   trans_id_i             : request tag
//   valid_o / ready_i      : result handshake
//   result_o, trans_id_o   : result and its tag
//
// Configuration macro:
//   BITMANIP_EARLY_EXIT_EN : when defined, BUSY finishes as soon as no set
//                            mask bits remain above the current slice.
//                            Results do not change, only the latency.
module bitmanip_multicycle
    import ariane_pkg::*;
#(
    parameter int unsigned XLEN           = 64,
    parameter int unsigned BITS_PER_CYCLE = 8,
    parameter int unsigned TRANS_ID_W     = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  bitmanip_op_e          op_i,
    input  logic                  word_i,
    input  logic [XLEN-1:0]       operand_a_i,
    input  logic [XLEN-1:0]       operand_b_i,
    input  logic [TRANS_ID_W-1:0] trans_id_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [XLEN-1:0]       result_o,
    output logic [TRANS_ID_W-1:0] trans_id_o
);

    localparam int unsigned IW = $clog2(XLEN);
    localparam int unsigned KW = IW + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [XLEN-1:0] LO32_MASK = XLEN'(64'h0000_0000_FFFF_FFFF);
    localparam logic [IW-1:0]   LAST_D    = IW'(XLEN / BITS_PER_CYCLE - 1);
    localparam logic [IW-1:0]   LAST_W    = IW'(32 / BITS_PER_CYCLE - 1);

    logic [1:0]            state_q,  state_d;
    bitmanip_op_e          op_q,     op_d;
    logic                  word_q,   word_d;
    logic [XLEN-1:0]       a_q,      a_d;
    logic [XLEN-1:0]       mask_q,   mask_d;   // shifted right one slice per cycle
    logic [XLEN-1:0]       acc_q,    acc_d;
    logic [KW-1:0]         k_q,      k_d;
    logic [IW-1:0]         cnt_q,    cnt_d;    // index of the slice being processed
    logic [XLEN-1:0]       result_q, result_d;
    logic [TRANS_ID_W-1:0] tag_q,    tag_d;

    logic [XLEN-1:0] step_acc;
    logic [KW-1:0]   step_k;
    logic [IW-1:0]   base;
    logic [XLEN-1:0] final_res;
    logic            last_slice;

    assign base = IW'(cnt_q * BITS_PER_CYCLE);

    bitmanip_step #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .op_i    (op_q),
        .a_i     (a_q),
        .slice_i (mask_q[BITS_PER_CYCLE-1:0]),
        .base_i  (base),
        .k_i     (k_q),
        .acc_i   (acc_q),
        .acc_o   (step_acc),
        .k_o     (step_k)
    );

    // The W variant replicates bit 31 into the upper half of the result.
    always_comb begin
        final_res = step_acc;
        if (word_q) begin
            for (int i = 32; i < int'(XLEN); i++) begin
                final_res[i] = step_acc[31];
            end
        end
    end

`ifdef BITMANIP_EARLY_EXIT_EN
    assign last_slice = (cnt_q == (word_q ? LAST_W : LAST_D)) ||
                        ((mask_q >> BITS_PER_CYCLE) == '0);
`else
    assign last_slice = (cnt_q == (word_q ? LAST_W : LAST_D));
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        word_d   = word_q;
        a_d      = a_q;
        mask_d   = mask_q;
        acc_d    = acc_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        tag_d    = tag_q;

        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    op_d    = op_i;
                    word_d  = word_i;
                    // Upper operand bits are dropped up front so the W variant
                    // never sees them, which also keeps early exit correct.
                    a_d     = word_i ? (operand_a_i & LO32_MASK) : operand_a_i;
                    mask_d  = word_i ? (operand_b_i & LO32_MASK) : operand_b_i;
                    tag_d   = trans_id_i;
                    acc_d   = '0;
                    k_d     = '0;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                acc_d  = step_acc;
                k_d    = step_k;
                mask_d = mask_q >> BITS_PER_CYCLE;
                cnt_d  = cnt_q + IW'(1);
                if (last_slice) begin
                    result_d = final_res;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A flush overrides everything above, including a same-cycle accept.
        if (flush_i) begin
            state_d  = S_IDLE;
            result_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            op_q     <= BEXT;
            word_q   <= 1'b0;
            a_q      <= '0;
            mask_q   <= '0;
            acc_q    <= '0;
            k_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            tag_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            word_q   <= word_d;
            a_q      <= a_d;
            mask_q   <= mask_d;
            acc_q    <= acc_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            tag_q    <= tag_d;
        end
    end

    assign ready_o    = (state_q == S_IDLE);
    assign valid_o    = (state_q == S_DONE);
    assign result_o   = result_q;
    assign trans_id_o = tag_q;

endmodule

// File: tb/tb_bitmanip_multicycle.sv
// tb_bitmanip_multicycle -- directed, table-driven bench for bitmanip_multicycle
// (XLEN=64, BITS_PER_CYCLE=8). The expected latency follows
// BITMANIP_EARLY_EXIT_EN when the bench is compiled with that macro.
module tb_bitmanip_multicycle;
    import ariane_pkg::*;

    localparam int XLEN = 64;

    typedef struct {
        bitmanip_op_e op;
        logic         word;
        logic [63:0]  a;
        logic [63:0]  b;
        logic [2:0]   tag;
        logic [63:0]  exp_res;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        valid_in = 1'b0;
    logic        ready_out;
    bitmanip_op_e op = BEXT;
    logic        word = 1'b0;
    logic [63:0] opa = '0;
    logic [63:0] opb = '0;
    logic [2:0]  tid_in = '0;
    logic        valid_out;
    logic        ready_in = 1'b0;
    logic [63:0] result;
    logic [2:0]  tid_out;

    int checks = 0;
    int errors = 0;

    vec_t vecs[11];

    bitmanip_multicycle #(
        .XLEN(64), .BITS_PER_CYCLE(8), .TRANS_ID_W(3)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .valid_i     (valid_in),
        .ready_o     (ready_out),
        .op_i        (op),
        .word_i      (word),
        .operand_a_i (opa),
        .operand_b_i (opb),
        .trans_id_i  (tid_in),
        .valid_o     (valid_out),
        .ready_i     (ready_in),
        .result_o    (result),
        .trans_id_o  (tid_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_latency(input logic w, input logic [63:0] b);
        int n;
`ifdef BITMANIP_EARLY_EXIT_EN
        logic [63:0] m;
        int msb;
        m = w ? (b & 64'h0000_0000_FFFF_FFFF) : b;
        msb = -1;
        for (int i = 0; i < 64; i++) if (m[i]) msb = i;
        n = (msb + 1 + 7) / 8;
        if (n < 1) n = 1;
`else
        n = w ? 4 : 8;
`endif
        return n;
    endfunction

    // Present one request, the accept happens on the next rising edge.
    task automatic accept(input vec_t v);
        chk("ready_before_accept", {63'd0, ready_out}, 64'd1);
        op = v.op; word = v.word; opa = v.a; opb = v.b; tid_in = v.tag;
        valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        chk("ready_low_in_busy", {63'd0, ready_out}, 64'd0);
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (!valid_out && edges < 200);
        if (!valid_out) chk("valid_timeout", {63'd0, valid_out}, 64'd1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int edges;
        accept(v);
        wait_valid(edges);
        chk("latency", 64'(edges), 64'(exp_latency(v.word, v.b)));
        chk("result", result, v.exp_res);
        chk("trans_id", {61'd0, tid_out}, {61'd0, v.tag});
        $display("vec %0d: op=%s word=%0d a=%h b=%h -> result=%h tag=%0d lat=%0d",
                 idx, v.op.name(), v.word, v.a, v.b, result, tid_out, edges);
        ready_in = 1'b1;
        @(posedge clk); #1;
        ready_in = 1'b0;
        chk("valid_drop_after_ready", {63'd0, valid_out}, 64'd0);
        chk("ready_back_after_ready", {63'd0, ready_out}, 64'd1);
    endtask

    initial begin
        int edges;
        int seen_valid;
        logic [63:0] held_res;
        logic [2:0]  held_tid;
        vec_t v;

        vecs[0]  = '{BEXT, 1'b0, 64'hFFFF0000_12345678, 64'h00000000_0000FF00, 3'd1, 64'h56};
        vecs[1]  = '{BDEP, 1'b0, 64'h0F,                64'hF0F0,              3'd5, 64'hF0};
        vecs[2]  = '{BDEP, 1'b1, 64'h1,                 64'h80000000,          3'd2, 64'hFFFFFFFF_80000000};
        vecs[3]  = '{BEXT, 1'b0, 64'h12345678_9ABCDEF0, 64'h0,                 3'd3, 64'h0};
        vecs[4]  = '{BEXT, 1'b0, 64'h01234567_89ABCDEF, 64'hFFFFFFFF_FFFFFFFF, 3'd7, 64'h01234567_89ABCDEF};
        vecs[5]  = '{BDEP, 1'b0, 64'hDEADBEEF_CAFEF00D, 64'hFFFFFFFF_FFFFFFFF, 3'd4, 64'hDEADBEEF_CAFEF00D};
        vecs[6]  = '{BEXT, 1'b0, 64'h1,                 64'h1,                 3'd6, 64'h1};
        vecs[7]  = '{BEXT, 1'b1, 64'hFFFFFFFF_000000F0, 64'hFFFFFFFF_000000F0, 3'd1, 64'hF};
        vecs[8]  = '{BEXT, 1'b1, 64'h80000000,          64'hFFFFFFFF,          3'd2, 64'hFFFFFFFF_80000000};
        vecs[9]  = '{BEXT, 1'b0, 64'hFFFFFFFF_00000000, 64'hAAAAAAAA_AAAAAAAA, 3'd3, 64'h00000000_FFFF0000};
        vecs[10] = '{BDEP, 1'b0, 64'h5A,                64'hFF000000_00000000, 3'd0, 64'h5A000000_00000000};

        // Reset state
        #12;
        chk("reset_valid", {63'd0, valid_out}, 64'd0);
        chk("reset_result", result, 64'd0);
        chk("reset_tid", {61'd0, tid_out}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", {63'd0, ready_out}, 64'd1);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Flush in the third BUSY cycle: no result, then a clean BEXT.
        v = '{BEXT, 1'b0, 64'hFF, 64'hFF000000_00000000, 3'd6, 64'h0};
        accept(v);
        repeat (2) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_ready", {63'd0, ready_out}, 64'd1);
        chk("flush_valid", {63'd0, valid_out}, 64'd0);
        seen_valid = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (valid_out) seen_valid = 1;
        end
        chk("flush_no_valid_later", 64'(seen_valid), 64'd0);
        $display("flush in BUSY: ready=%0d valid_seen=%0d", ready_out, seen_valid);
        run_vec(vecs[0], 0);

        // Consumer stalls for 5 cycles in DONE.
        accept(vecs[1]);
        wait_valid(edges);
        held_res = result;
        held_tid = tid_out;
        chk("stall_first_result", held_res, 64'hF0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("stall_result", result, held_res);
            chk("stall_tid", {61'd0, tid_out}, {61'd0, held_tid});
            chk("stall_valid", {63'd0, valid_out}, 64'd1);
            chk("stall_ready", {63'd0, ready_out}, 64'd0);
        end
        $display("stall in DONE: result=%h tag=%0d held for 5 cycles", result, tid_out);

        // Flush in DONE drops the result.
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        chk("flush_done_valid", {63'd0, valid_out}, 64'd0);
        chk("flush_done_ready", {63'd0, ready_out}, 64'd1);
        $display("flush in DONE: valid=%0d ready=%0d", valid_out, ready_out);

        // Leave a nonzero result and tag behind, then reset mid-BUSY.
        run_vec(vecs[4], 4);
        accept(vecs[5]);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", {63'd0, valid_out}, 64'd0);
        chk("rst_mid_result", result, 64'd0);
        chk("rst_mid_tid", {61'd0, tid_out}, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_ready", {63'd0, ready_out}, 64'd1);
        $display("reset mid-BUSY: valid=%0d result=%h tag=%0d ready=%0d",
                 valid_out, result, tid_out, ready_out);
        run_vec(vecs[2], 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
